chaos_uart_tx: RTL and testbench

CHAOS_UART_TX -- requirements
Module: chaos_uart_tx

---
 rtl/chaos_uart_pkg.sv | 14 +
 rtl/chaos_uart_fifo.sv | 60 ++++++
 rtl/chaos_uart_tx.sv | 123 ++++++++++++
 tb/tb_chaos_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chaos_uart_pkg.sv
// Shared constants for the chaos UART transmitter: state encodings and frame geometry.
package chaos_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS      = 10;
    localparam int DEFAULT_CLK_DIV = 16;

endpackage

// File: rtl/chaos_uart_fifo.sv
// Small power-of-two FIFO with occupancy count; read data is the current head entry.
module chaos_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    head_reg;
    logic [AW-1:0]    tail_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign empty    = (count_reg == '0);
    // Guards use registered occupancy, so a pop never frees room for a same-edge push.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_reg[head_reg];
    assign count    = count_reg;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_reg[tail_reg] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (do_push) begin
                tail_reg <= tail_reg + AW'(1);
            end
            if (do_pop) begin
                head_reg <= head_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/chaos_uart_tx.sv
// 8N1 UART transmitter fed by a small FIFO; back-to-back frames have no idle gap.
module chaos_uart_tx
    import chaos_uart_pkg::*;
#(
    parameter int CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLK_DIV - 1);

    tx_state_t     state_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          ser_reg;

    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_data;
    logic          bit_done;
    logic          pop;

    assign bit_done = (cnt_reg == CNT_LAST);
    assign pop      = !fifo_empty && ((state_reg == IDLE) || (state_reg == STOP && bit_done));

    chaos_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetb    (resetb),
        .push      (data_valid),
        .push_data (data_in),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign data_ready = !fifo_full;
    assign busy       = (state_reg != IDLE) || !fifo_empty;
    assign ser_tx     = ser_reg;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            ser_reg     <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    ser_reg <= 1'b1;
                    cnt_reg <= '0;
                    if (!fifo_empty) begin
                        shift_reg <= fifo_data;
                        ser_reg   <= 1'b0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        cnt_reg     <= '0;
                        ser_reg     <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            ser_reg   <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            ser_reg     <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        cnt_reg <= '0;
                        // Chain straight into the next start bit when more data is waiting.
                        if (!fifo_empty) begin
                            shift_reg <= fifo_data;
                            ser_reg   <= 1'b0;
                            state_reg <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ser_reg   <= 1'b1;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chaos_uart_tx.sv
// Randomized and directed bench for chaos_uart_tx against a queue-based frame-timing model.
module tb_chaos_uart_tx;
    import chaos_uart_pkg::*;

    localparam int D     = 4;
    localparam int D2    = 2;
    localparam int DEPTH = 4;
    localparam int FLEN  = FRAME_BITS * D;

    logic       clock = 1'b0;
    logic       resetb;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       ser_tx;
    logic       busy;
    logic [2:0] fifo_count;

    logic [7:0] d2_data;
    logic       d2_valid;
    logic       d2_ready;
    logic       d2_ser;
    logic       d2_busy;
    logic [2:0] d2_count;

    always #5 clock = ~clock;

    chaos_uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .ser_tx     (ser_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    chaos_uart_tx #(.CLK_DIV(D2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clock      (clock),
        .resetb     (resetb),
        .data_in    (d2_data),
        .data_valid (d2_valid),
        .data_ready (d2_ready),
        .ser_tx     (d2_ser),
        .busy       (d2_busy),
        .fifo_count (d2_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bytes waiting, plus the byte on the wire and cycles since its start edge.
    logic [7:0] q_model[$];
    logic [7:0] frame_byte;
    int         frame_t = -1;

    function automatic logic exp_ser();
        int b;
        if (frame_t < 0) return 1'b1;
        b = frame_t / D;
        if (b == 0) return 1'b0;
        if (b == FRAME_BITS - 1) return 1'b1;
        return frame_byte[b-1];
    endfunction

    task automatic model_reset();
        q_model.delete();
        frame_t = -1;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        logic accept;
        logic start;
        accept = v && (q_model.size() < DEPTH);
        start  = ((frame_t < 0) || (frame_t == FLEN - 1)) && (q_model.size() > 0);
        if (frame_t >= 0) begin
            frame_t++;
            if (frame_t == FLEN) frame_t = -1;
        end
        if (start) begin
            frame_byte = q_model.pop_front();
            frame_t    = 0;
            $display("tx frame start byte 0x%02h at %0t", frame_byte, $time);
        end
        if (accept) q_model.push_back(d);
    endtask

    task automatic cycle(input logic v, input logic [7:0] d);
        data_valid = v;
        data_in    = d;
        @(posedge clock);
        model_step(v, d);
        #1;
        check("ser_tx", 32'(ser_tx), 32'(exp_ser()));
        check("fifo_count", 32'(fifo_count), 32'(q_model.size()));
        check("data_ready", 32'(data_ready), 32'(q_model.size() != DEPTH));
        check("busy", 32'(busy), 32'((frame_t >= 0) || (q_model.size() > 0)));
        data_valid = 1'b0;
    endtask

    task automatic wait_frame_t(input int target);
        int k;
        k = 0;
        while (frame_t != target && k < 300) begin
            cycle(1'b0, 8'h00);
            k++;
        end
        check("wait_bound", 32'(k < 300), 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((frame_t >= 0 || q_model.size() > 0) && k < 400) begin
            cycle(1'b0, 8'h00);
            k++;
        end
        check("drain_bound", 32'(k < 400), 32'd1);
        cycle(1'b0, 8'h00);
    endtask

    logic       cap_ser  [41];
    logic       cap_busy [41];
    logic [9:0] pat;
    logic       s_ser    [25];
    logic       s_busy   [25];
    int         acc;
    int         lows;
    int         highs;
    int         busy_cnt;
    logic [7:0] rb;

    initial begin
        resetb     = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        d2_valid   = 1'b0;
        d2_data    = 8'h00;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_ser", 32'(ser_tx), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst2_ser", 32'(d2_ser), 32'd1);
        #2 resetb = 1'b1;

        // Single byte 0xA5 with exact bit-level timing.
        cycle(1'b1, 8'hA5);
        for (int i = 0; i < 41; i++) begin
            cycle(1'b0, 8'h00);
            cap_ser[i]  = ser_tx;
            cap_busy[i] = busy;
        end
        pat = 10'b1101001010;
        for (int i = 0; i < 40; i++) check("a5_bit", 32'(cap_ser[i]), 32'(pat[i/4]));
        check("a5_busy_last", 32'(cap_busy[39]), 32'd1);
        check("a5_busy_fall", 32'(cap_busy[40]), 32'd0);

        // Eight offered bytes: only five fit, frames run back to back.
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (data_ready) acc++;
            cycle(1'b1, 8'(i));
        end
        check("accepted_of_8", 32'(acc), 32'd5);
        drain();

        // Push offered while full on the same edge as a pop is rejected.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i));
        wait_frame_t(FLEN - 1);
        check("full_before_pop", 32'(data_ready), 32'd0);
        cycle(1'b1, 8'hEE);
        check("pop_while_full", 32'(fifo_count), 32'd3);
        drain();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            rb = 8'($urandom);
            cycle(($urandom_range(0, 2) == 0), rb);
        end
        drain();

        // Asynchronous reset during data bit 3 with two bytes queued.
        cycle(1'b1, 8'h00);
        cycle(1'b1, 8'h11);
        cycle(1'b1, 8'h22);
        wait_frame_t(4 * D + 1);
        check("pre_rst_low", 32'(ser_tx), 32'd0);
        #3 resetb = 1'b0;
        #1;
        check("async_ser", 32'(ser_tx), 32'd1);
        check("async_count", 32'(fifo_count), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(data_ready), 32'd1);
        model_reset();
        repeat (2) @(posedge clock);
        #2 resetb = 1'b1;
        cycle(1'b1, 8'h3C);
        for (int i = 0; i < 50; i++) cycle(1'b0, 8'h00);

        // CLK_DIV=2 instance, byte 0xFF.
        d2_valid = 1'b1;
        d2_data  = 8'hFF;
        @(posedge clock);
        #1;
        d2_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock);
            #1;
            s_ser[i]  = d2_ser;
            s_busy[i] = d2_busy;
        end
        lows = 0;
        highs = 0;
        busy_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (!s_ser[i]) lows++;
            if (s_busy[i]) busy_cnt++;
            if (s_busy[i] && s_ser[i]) highs++;
        end
        check("d2_first_low", 32'(s_ser[0]), 32'd0);
        check("d2_low_cycles", 32'(lows), 32'd2);
        check("d2_high_cycles", 32'(highs), 32'd18);
        check("d2_frame_len", 32'(busy_cnt), 32'd20);
        check("d2_busy_fall", 32'(s_busy[20]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
